// File: rtl/regwrite_pkg.sv
// regwrite_pkg: shared constants, FSM state type and decode helpers for the
// register-file write scheduler.
package regwrite_pkg;

  // Write-back mux select values, one per mux input.
  localparam logic [2:0] SEL_0        = 3'd0;
  localparam logic [2:0] SEL_1        = 3'd1;
  localparam logic [2:0] SEL_2        = 3'd2;
  localparam logic [2:0] SEL_3        = 3'd3;
  localparam logic [2:0] SEL_4        = 3'd4;
  localparam logic [2:0] SEL_5        = 3'd5;
  localparam logic [2:0] SEL_6        = 3'd6;
  localparam logic [2:0] SEL_7        = 3'd7;
  // Mux input 6 is hard-wired to the constant 227 (init value for SP).
  localparam logic [2:0] SEL_CONST227 = 3'd6;

  // Sources that may request a write; bit 6 is the constant input.
  localparam logic [7:0] SRC_MASK     = 8'b1011_1111;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Encode a one-hot grant into the matching mux select.
  function automatic logic [2:0] onehot_to_sel(input logic [7:0] oh);
    logic [2:0] sel;
    case (oh)
      8'b0000_0001: sel = SEL_0;
      8'b0000_0010: sel = SEL_1;
      8'b0000_0100: sel = SEL_2;
      8'b0000_1000: sel = SEL_3;
      8'b0001_0000: sel = SEL_4;
      8'b0010_0000: sel = SEL_5;
      8'b0100_0000: sel = SEL_6;
      8'b1000_0000: sel = SEL_7;
      default:      sel = SEL_0;
    endcase
    return sel;
  endfunction

  // Extract the 5-bit destination field belonging to source 'sel'.
  function automatic logic [4:0] dst_field(input logic [39:0] dst_bus,
                                           input logic [2:0]  sel);
    logic [4:0] f;
    f = 5'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel == 3'(i)) begin
        f = dst_bus[i*5 +: 5];
      end else begin
        f = f;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational rotate-priority picker. Searches req_i starting at
// ptr_i + 1 (wrapping modulo 8) and returns the first set bit one-hot.
module rr_pick8 (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [7:0] pick_o,
  output logic       valid_o
);

  logic [2:0] idx;

  // Walk the eight positions after the pointer; first hit wins.
  always_comb begin
    pick_o  = 8'h00;
    valid_o = 1'b0;
    idx     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_i + 3'(k);
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/regwrite_sched.sv
// regwrite_sched: schedules register-file writes from up to seven write-back
// sources. After reset an optional init write loads SP_REG from the constant
// mux input; afterwards requests are arbitrated round-robin and the chosen
// source's select, address and write enable are presented one cycle later.
// Optional feature: define REGWRITE_STALL_CNT_EN to add the 16-bit saturating
// stall_cnt output.
module regwrite_sched
  import regwrite_pkg::*;
#(
  parameter logic [4:0] SP_REG     = 5'd29,
  parameter bit         INIT_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [39:0] dst,
  input  logic        stall,
  output logic [2:0]  mem_to_reg,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [7:0]  grant,
  output logic        init_done
`ifdef REGWRITE_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  state_e     state_q,      state_d;
  logic [7:0] grant_q,      grant_d;
  logic [2:0] mem_to_reg_q, mem_to_reg_d;
  logic [4:0] write_reg_q,  write_reg_d;
  logic       reg_write_q,  reg_write_d;
  logic       init_done_q,  init_done_d;
  logic [2:0] ptr_q,        ptr_d;

  logic [7:0] eligible_s;
  logic [7:0] pick_s;
  logic       pick_valid_s;
  logic [2:0] pick_sel_s;
  logic [4:0] pick_dst_s;

  // A source granted this cycle still shows req; mask it so it is not
  // granted twice while the requester reacts.
  assign eligible_s = req & SRC_MASK & ~grant_q;

  rr_pick8 u_pick (
    .req_i   (eligible_s),
    .ptr_i   (ptr_q),
    .pick_o  (pick_s),
    .valid_o (pick_valid_s)
  );

  assign pick_sel_s = onehot_to_sel(pick_s);
  assign pick_dst_s = dst_field(dst, pick_sel_s);

  // Next-state and next-output logic for the INIT/RUN sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = 8'h00;
    reg_write_d  = 1'b0;
    mem_to_reg_d = mem_to_reg_q;
    write_reg_d  = write_reg_q;
    ptr_d        = ptr_q;
    init_done_d  = (state_q == RUN);
    case (state_q)
      INIT: begin
        if (INIT_WRITE) begin
          mem_to_reg_d = SEL_CONST227;
          write_reg_d  = SP_REG;
          reg_write_d  = 1'b1;
        end else begin
          reg_write_d  = 1'b0;
        end
        state_d = RUN;
      end
      RUN: begin
        if (!stall && pick_valid_s) begin
          grant_d      = pick_s;
          mem_to_reg_d = pick_sel_s;
          write_reg_d  = pick_dst_s;
          // Register 0 is never written, but the source is still acknowledged.
          reg_write_d  = (pick_dst_s != 5'd0);
          ptr_d        = pick_sel_s;
        end else begin
          grant_d      = 8'h00;
          reg_write_d  = 1'b0;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      grant_q      <= 8'h00;
      mem_to_reg_q <= 3'd0;
      write_reg_q  <= 5'd0;
      reg_write_q  <= 1'b0;
      init_done_q  <= 1'b0;
      ptr_q        <= 3'd7;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      init_done_q  <= init_done_d;
      ptr_q        <= ptr_d;
    end
  end

  assign grant      = grant_q;
  assign mem_to_reg = mem_to_reg_q;
  assign write_reg  = write_reg_q;
  assign reg_write  = reg_write_q;
  assign init_done  = init_done_q;

`ifdef REGWRITE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count RUN cycles in which a stall holds back a pending request.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == RUN) && stall && (eligible_s != 8'h00) &&
        (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regwrite_sched.sv
// tb_regwrite_sched: scoreboard bench for regwrite_sched. Expected write-back
// records are queued when a request is driven and compared when grant fires.
module tb_regwrite_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [39:0] dst;
  logic        stall;
  logic [2:0]  mem_to_reg;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [7:0]  grant;
  logic        init_done;
`ifdef REGWRITE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] sel;
    logic [4:0] wr;
    logic       we;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  regwrite_sched #(.SP_REG(5'd29), .INIT_WRITE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .dst        (dst),
    .stall      (stall),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .grant      (grant),
    .init_done  (init_done)
`ifdef REGWRITE_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Advance negedge by negedge until a grant appears or the budget runs out.
  task automatic wait_grant(input int budget, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      if (grant !== 8'h00) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'h00; dst = 40'h0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({grant, mem_to_reg, write_reg, reg_write, init_done} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {grant, mem_to_reg, write_reg, reg_write, init_done});
    end
`ifdef REGWRITE_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({reg_write, mem_to_reg, write_reg, grant, init_done} !==
        {1'b1, 3'd6, 5'd29, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL init_write got we=%b sel=%0d wr=%0d g=%h done=%b want we=1 sel=6 wr=29 g=00 done=0",
               reg_write, mem_to_reg, write_reg, grant, init_done);
    end
    @(negedge clk);
    total++;
    if (init_done !== 1'b1 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL init_done got done=%b we=%b want done=1 we=0", init_done, reg_write);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   seen;
    int   w;
    int   stray;
    exp_q.delete();
    for (int i = 0; i < 8; i++) dst[i*5 +: 5] = 5'(i + 10);
    req = 8'hBF;
    for (int i = 0; i < 8; i++) begin
      if (i != 6) exp_q.push_back('{g: 8'(1 << i), sel: 3'(i), wr: 5'(i + 10), we: 1'b1});
    end
    for (int n = 0; n < 7; n++) begin
      wait_grant(6, seen, w);
      total++;
      if (!seen) begin
        bad++; $display("FAIL rr_timeout got=none want=grant #%0d", n);
        break;
      end
      e = exp_q.pop_front();
      total++;
      if ({grant, mem_to_reg, write_reg, reg_write} !== e) begin
        bad++;
        $display("FAIL rr_order got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
                 grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
      end
      req = req & ~grant;
    end
    req = 8'h00;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (grant !== 8'h00) stray++;
    end
    total++;
    if (stray != 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL rr_tail got stray=%0d left=%0d want 0/0", stray, exp_q.size());
    end
  endtask

  task automatic test_single();
    exp_t e;
    bit   seen;
    int   w;
    int   stray;
    exp_q.delete();
    dst[4:0] = 5'd5;
    req = 8'h01;
    exp_q.push_back('{g: 8'h01, sel: 3'd0, wr: 5'd5, we: 1'b1});
    wait_grant(6, seen, w);
    total++;
    if (!seen || w != 1) begin
      bad++; $display("FAIL single_latency got seen=%b cycles=%0d want seen=1 cycles=1", seen, w);
    end
    e = exp_q.pop_front();
    total++;
    if ({grant, mem_to_reg, write_reg, reg_write} !== e) begin
      bad++;
      $display("FAIL single_grant got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
               grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
    end
    // Requester reacts one edge late: req is still high at the next sample.
    stray = 0;
    @(negedge clk);
    if (grant !== 8'h00) stray++;
    req = 8'h00;
    repeat (4) begin
      @(negedge clk);
      if (grant !== 8'h00) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL single_double_grant got=%0d want=0", stray);
    end
  endtask

  task automatic test_zero_dst();
    exp_t e;
    bit   seen;
    int   w;
    exp_q.delete();
    dst[19:15] = 5'd0;
    req = 8'h08;
    exp_q.push_back('{g: 8'h08, sel: 3'd3, wr: 5'd0, we: 1'b0});
    wait_grant(6, seen, w);
    total++;
    if (!seen) begin
      bad++; $display("FAIL zero_dst_timeout got=none want=08");
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({grant, mem_to_reg, write_reg, reg_write} !== e) begin
        bad++;
        $display("FAIL zero_dst got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
                 grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
      end
    end
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    exp_t e;
    bit   seen;
    int   w;
    exp_q.delete();
    dst[9:5] = 5'd7;
    stall = 1'b1;
    req   = 8'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (grant !== 8'h00 || reg_write !== 1'b0 ||
          {mem_to_reg, write_reg} !== {3'd3, 5'd0}) begin
        bad++;
        $display("FAIL stall_hold got g=%h we=%b sel=%0d wr=%0d want g=00 we=0 sel=3 wr=0",
                 grant, reg_write, mem_to_reg, write_reg);
      end
    end
    stall = 1'b0;
    exp_q.push_back('{g: 8'h02, sel: 3'd1, wr: 5'd7, we: 1'b1});
    wait_grant(4, seen, w);
    total++;
    if (!seen || w != 1) begin
      bad++; $display("FAIL stall_release got seen=%b cycles=%0d want seen=1 cycles=1", seen, w);
    end
    e = exp_q.pop_front();
    total++;
    if ({grant, mem_to_reg, write_reg, reg_write} !== e) begin
      bad++;
      $display("FAIL stall_grant got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
               grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
    end
`ifdef REGWRITE_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'd4) begin
      bad++; $display("FAIL stall_cnt got=%0d want=4", stall_cnt);
    end
`endif
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bit6();
    exp_t e;
    bit   seen;
    int   w;
    int   stray;
    exp_q.delete();
    dst[4:0] = 5'd3;
    req = 8'h41;
    exp_q.push_back('{g: 8'h01, sel: 3'd0, wr: 5'd3, we: 1'b1});
    wait_grant(6, seen, w);
    total++;
    if (!seen) begin
      bad++; $display("FAIL bit6_timeout got=none want=01");
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({grant, mem_to_reg, write_reg, reg_write} !== e) begin
        bad++;
        $display("FAIL bit6_grant got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
                 grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
      end
    end
    req = 8'h40;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (grant !== 8'h00) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL bit6_never got=%0d grants want=0", stray);
    end
    req = 8'h00;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    int   w;
    exp_q.delete();
    dst[24:20] = 5'd9;
    req = 8'h10;
    exp_q.push_back('{g: 8'h10, sel: 3'd4, wr: 5'd9, we: 1'b1});
    wait_grant(6, seen, w);
    e = exp_q.pop_front();
    total++;
    if (!seen || {grant, mem_to_reg, write_reg, reg_write} !== e) begin
      bad++;
      $display("FAIL mid_pre_grant got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
               grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
    end
    reset = 1'b1;
    req   = 8'h00;
    @(negedge clk);
    total++;
    if (grant !== 8'h00 || init_done !== 1'b0 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got g=%h done=%b we=%b want g=00 done=0 we=0",
               grant, init_done, reg_write);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({reg_write, mem_to_reg, write_reg, grant} !== {1'b1, 3'd6, 5'd29, 8'h00}) begin
      bad++;
      $display("FAIL mid_init_write got we=%b sel=%0d wr=%0d g=%h want we=1 sel=6 wr=29 g=00",
               reg_write, mem_to_reg, write_reg, grant);
    end
    @(negedge clk);
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL mid_init_done got=%b want=1", init_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   seen;
    int   w;
    exp_q.delete();
    dst[14:10] = 5'd12;
    dst[39:35] = 5'd17;
    dst[4:0]   = 5'd20;
    exp_q.push_back('{g: 8'h04, sel: 3'd2, wr: 5'd12, we: 1'b1});
    exp_q.push_back('{g: 8'h80, sel: 3'd7, wr: 5'd17, we: 1'b1});
    exp_q.push_back('{g: 8'h01, sel: 3'd0, wr: 5'd20, we: 1'b1});
    exp_q.push_back('{g: 8'h80, sel: 3'd7, wr: 5'd17, we: 1'b1});
    req = 8'h84;
    for (int n = 0; n < 4; n++) begin
      if (n == 2) req = 8'h81;
      wait_grant(6, seen, w);
      total++;
      if (!seen || w != 1) begin
        bad++; $display("FAIL b2b_timing got seen=%b cycles=%0d want seen=1 cycles=1 (#%0d)", seen, w, n);
      end
      if (!seen) break;
      e = exp_q.pop_front();
      total++;
      if ({grant, mem_to_reg, write_reg, reg_write} !== e) begin
        bad++;
        $display("FAIL b2b_order got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
                 grant, mem_to_reg, write_reg, reg_write, e.g, e.sel, e.wr, e.we);
      end
      req = req & ~grant;
    end
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    dst   = 40'h0;
    stall = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_zero_dst();
    test_stall();
    test_bit6();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regwrite_sched.md
REGWRITE_SCHED -- requirements
Module: regwrite_sched

Interface
REQ-001 SHALL have parameter SP_REG, default 5'd29: destination register for the post-reset init write.
REQ-002 SHALL have parameter INIT_WRITE, default 1: 1 = perform the init write after reset, 0 = skip it.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 8: write requests; bit i selects write-back mux input i; bit 6 is ignored (reserved for constant 227).
REQ-006 SHALL have port dst, input, 40: destination register for source i at bits [5i+4:5i].
REQ-007 SHALL have port stall, input, 1: when high, no grant is issued.
REQ-008 SHALL have port mem_to_reg, output, 3: write-back mux select.
REQ-009 SHALL have port reg_write, output, 1: register-file write enable.
REQ-010 SHALL have port write_reg, output, 5: register-file write address.
REQ-011 SHALL have port grant, output, 8: one-hot acknowledge, one-cycle pulse.
REQ-012 SHALL have port init_done, output, 1: high once the init phase has ended.

Function
REQ-013 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-014 INIT, INIT_WRITE=1: SHALL issue mem_to_reg=6, write_reg=SP_REG, reg_write=1, grant=0 for exactly one cycle, then enter RUN.
REQ-015 INIT, INIT_WRITE=0: SHALL enter RUN after one cycle with reg_write=0.
REQ-016 init_done SHALL be 0 in INIT and 1 in RUN.
REQ-017 RUN: SHALL sample req in cycle N and present grant, mem_to_reg, write_reg and reg_write, all registered, in cycle N+1.
REQ-018 Arbitration SHALL be round-robin: the search starts at last-granted index + 1, modulo 8, and skips bit 6.
REQ-019 A source granted in cycle N+1 SHALL be masked from the arbitration sampled in cycle N+1, so a held req is never double-granted.
REQ-020 With no eligible req, or with stall=1, SHALL drive grant=0 and reg_write=0, hold the last-grant pointer, and hold mem_to_reg and write_reg.
REQ-021 A granted request whose dst is 0 SHALL still receive grant, with reg_write=0.
REQ-022 Requesters SHALL hold req and dst stable until grant is seen. The block SHALL NOT latch dst beyond the grant cycle.
REQ-023 grant SHALL have at most one bit set, and SHALL never have bit 6 set.

Reset
REQ-024 On reset=1 at a clock edge, outputs SHALL be: mem_to_reg=0, reg_write=0, write_reg=0, grant=0, init_done=0, stall_cnt=0.
REQ-025 On the same reset edge, the last-grant pointer SHALL be set to 7, so the first search starts at 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending grant and restart in INIT.

Configuration
REQ-027 With macro REGWRITE_STALL_CNT_EN defined, SHALL add output stall_cnt, 16 bits.
REQ-028 stall_cnt SHALL increment by 1 each RUN cycle in which stall=1 and any eligible req is high, and SHALL saturate at 16'hFFFF.
REQ-029 Without REGWRITE_STALL_CNT_EN, the port and the counter SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 Shared package regwrite_pkg SHALL hold the mux-select constants (SEL_0..SEL_7, SEL_CONST227=3'd6), the FSM state typedef, and SRC_MASK=8'b1011_1111.
REQ-031 A sub-module rr_pick8 SHALL exist: a combinational rotate-priority picker taking (req masked, pointer) and returning a one-hot result plus a valid flag.

Verification
REQ-032 Reset release, INIT_WRITE=1 -> cycle 1: reg_write=1, mem_to_reg=6, write_reg=29, grant=0; cycle 2: init_done=1.
REQ-033 req=8'h01, dst0=5, held until grant -> grant=8'h01, mem_to_reg=0, write_reg=5, reg_write=1 one cycle after sampling; exactly one grant.
REQ-034 req=8'hBF held continuously, each source dropping req after its grant -> grant order 0,1,2,3,4,5,7; bit 6 never granted.
REQ-035 req=8'h08, dst3=0 -> grant=8'h08, reg_write=0.
REQ-036 stall=1 for 4 cycles with req=8'h02 -> grant=0 throughout; grant=8'h02 one cycle after stall falls; stall_cnt=4 when the macro is defined.
REQ-037 reset pulsed in the cycle after a sampled req -> next cycle grant=0, init_done=0, and the INIT write reoccurs.
